perf_counter_unit: RTL and testbench

PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

---
 rtl/perf_counter_unit_pkg.sv | 41 ++++
 rtl/perf_counter.sv | 45 ++++
 rtl/perf_counter_unit.sv | 150 +++++++++++++++
 tb/tb_perf_counter_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/perf_counter_unit_pkg.sv
// Shared definitions for the performance counter unit: run-state encoding,
// register word indices, counter slots and the STATUS word packing.
package perf_counter_unit_pkg;

  localparam int PERF_NUM_CNT = 7;

  typedef enum logic [1:0] {
    PERF_IDLE    = 2'd0,
    PERF_RUN     = 2'd1,
    PERF_HALTED  = 2'd2
  } perf_state_t;

  // Register word indices
  localparam logic [4:0] PERF_REG_CTRL      = 5'd0;
  localparam logic [4:0] PERF_REG_STATUS    = 5'd1;
  localparam logic [4:0] PERF_REG_SNAP_BASE = 5'd2;
  localparam logic [4:0] PERF_REG_SNAP_LAST = 5'd15;

  // CTRL bit positions
  localparam int PERF_CTRL_EN    = 0;
  localparam int PERF_CTRL_CLEAR = 1;
  localparam int PERF_CTRL_SNAP  = 2;

  // Counter slots
  localparam int PERF_CNT_CYCLE   = 0;
  localparam int PERF_CNT_INSTR   = 1;
  localparam int PERF_CNT_ICACHE  = 2;
  localparam int PERF_CNT_DCACHE  = 3;
  localparam int PERF_CNT_UNCACHE = 4;
  localparam int PERF_CNT_BRANCH  = 5;
  localparam int PERF_CNT_MISPRED = 6;

  function automatic logic [31:0] perf_status_word(
    input perf_state_t              st,
    input logic                     snap_valid,
    input logic [PERF_NUM_CNT-1:0]  sticky
  );
    return {{(32 - 3 - PERF_NUM_CNT){1'b0}}, sticky, snap_valid, st};
  endfunction

endpackage

// File: rtl/perf_counter.sv
// One event counter: adds a 0..3 increment while enabled, clears with priority,
// and flags the cycle in which the addition carries out of the top bit.
module perf_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clear,
  input  logic [1:0]           inc,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 wrap
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic [CNT_WIDTH:0]   sum_ext;

  assign sum_ext = {1'b0, count_q} + (CNT_WIDTH + 1)'(inc);

  // NOTE: every always_comb output gets a default on entry so no path leaves
  // it unassigned; otherwise synthesis would infer a latch to hold it.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = sum_ext[CNT_WIDTH-1:0];
    end
  end

  // NOTE: clocked state uses <= so every flop samples pre-edge values; a
  // blocking = here would make results depend on block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = en & ~clear & sum_ext[CNT_WIDTH];

endmodule

// File: rtl/perf_counter_unit.sv
// Performance counter unit: seven event counters gated by an IDLE/RUN/HALTED
// state machine, snapshot copies for software reads, and a registered read port.
module perf_counter_unit
  import perf_counter_unit_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ev_icache_miss,
  input  logic        ev_dcache_miss,
  input  logic        ev_uncache,
  input  logic [1:0]  ev_retire,
  input  logic        ev_branch,
  input  logic        ev_mispredict,
  input  logic        ev_stop,
  input  logic        reg_we,
  input  logic        reg_re,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_rvalid
);

  perf_state_t             state_q;
  logic                    enable_q;
  logic                    snap_req_q;
  logic                    snap_valid_q;
  logic [PERF_NUM_CNT-1:0] sticky_q;
  logic [PERF_NUM_CNT-1:0] wrap;

  logic [CNT_WIDTH-1:0] count  [PERF_NUM_CNT];
  logic [CNT_WIDTH-1:0] snap_q [PERF_NUM_CNT];
  logic [1:0]           inc    [PERF_NUM_CNT];

  logic ctrl_wr;
  logic clear_pulse;
  logic snap_pulse;
  logic counting;
  logic stop_hit;

  assign ctrl_wr     = reg_we & (reg_addr == PERF_REG_CTRL);
  assign clear_pulse = ctrl_wr & reg_wdata[PERF_CTRL_CLEAR];
  assign snap_pulse  = ctrl_wr & reg_wdata[PERF_CTRL_SNAP];
  assign counting    = (state_q == PERF_RUN);
  assign stop_hit    = counting & ev_stop;

  logic unused_wdata;
  assign unused_wdata = ^reg_wdata[31:3];

  always_comb begin
    inc[PERF_CNT_CYCLE]   = 2'd1;
    inc[PERF_CNT_INSTR]   = ev_retire;
    inc[PERF_CNT_ICACHE]  = {1'b0, ev_icache_miss};
    inc[PERF_CNT_DCACHE]  = {1'b0, ev_dcache_miss};
    inc[PERF_CNT_UNCACHE] = {1'b0, ev_uncache};
    inc[PERF_CNT_BRANCH]  = {1'b0, ev_branch};
    inc[PERF_CNT_MISPRED] = {1'b0, ev_branch & ev_mispredict};
  end

  for (genvar i = 0; i < PERF_NUM_CNT; i++) begin : g_cnt
    perf_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (counting),
      .clear (clear_pulse),
      .inc   (inc[i]),
      .count (count[i]),
      .wrap  (wrap[i])
    );
  end

  // A CTRL write always decides the next state; ev_stop only matters in RUN.
  // The stop cycle's events are already in the counters when the auto snapshot
  // is taken, because the copy happens one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PERF_IDLE;
      enable_q   <= 1'b0;
      snap_req_q <= 1'b0;
    end else begin
      snap_req_q <= snap_pulse | stop_hit;
      if (ctrl_wr) begin
        enable_q <= reg_wdata[PERF_CTRL_EN];
        state_q  <= reg_wdata[PERF_CTRL_EN] ? PERF_RUN : PERF_IDLE;
      end else if (stop_hit) begin
        state_q <= PERF_HALTED;
      end
    end
  end

  // NOTE: the snapshot array is reset explicitly because software must read
  // zeros after reset; large storage without that need would skip the reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PERF_NUM_CNT; i++) begin
        snap_q[i] <= '0;
      end
      snap_valid_q <= 1'b0;
      sticky_q     <= '0;
    end else begin
      if (snap_req_q) begin
        for (int i = 0; i < PERF_NUM_CNT; i++) begin
          snap_q[i] <= count[i];
        end
        snap_valid_q <= 1'b1;
      end
      if (clear_pulse) begin
        sticky_q <= '0;
      end else begin
        sticky_q <= sticky_q | wrap;
      end
    end
  end

  // Read decode; snapshot words sit in low/high pairs from index 2 upward.
  logic [3:0]  snap_off;
  logic [2:0]  snap_idx;
  logic [63:0] snap_ext;
  logic [31:0] rd_word;

  assign snap_off = 4'(reg_addr - PERF_REG_SNAP_BASE);
  assign snap_idx = snap_off[3:1];
  assign snap_ext = 64'(snap_q[snap_idx]);

  always_comb begin
    rd_word = '0;
    if (reg_addr == PERF_REG_CTRL) begin
      rd_word = {31'b0, enable_q};
    end else if (reg_addr == PERF_REG_STATUS) begin
      rd_word = perf_status_word(state_q, snap_valid_q, sticky_q);
    end else if (reg_addr <= PERF_REG_SNAP_LAST) begin
      rd_word = snap_off[0] ? snap_ext[63:32] : snap_ext[31:0];
    end
  end

  // Sampling at the edge returns pre-write contents for a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_rvalid <= 1'b0;
      reg_rdata  <= '0;
    end else begin
      reg_rvalid <= reg_re;
      reg_rdata  <= reg_re ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit at CNT_WIDTH=33 with hand-computed
// expectations; inputs change and outputs are sampled on the falling edge.
module tb_perf_counter_unit;

  logic        clk;
  logic        rst;
  logic        ev_icache_miss;
  logic        ev_dcache_miss;
  logic        ev_uncache;
  logic [1:0]  ev_retire;
  logic        ev_branch;
  logic        ev_mispredict;
  logic        ev_stop;
  logic        reg_we;
  logic        reg_re;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;

  int n_cmp;
  int n_fail;

  perf_counter_unit #(
    .CNT_WIDTH (33)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ev_icache_miss (ev_icache_miss),
    .ev_dcache_miss (ev_dcache_miss),
    .ev_uncache     (ev_uncache),
    .ev_retire      (ev_retire),
    .ev_branch      (ev_branch),
    .ev_mispredict  (ev_mispredict),
    .ev_stop        (ev_stop),
    .reg_we         (reg_we),
    .reg_re         (reg_re),
    .reg_addr       (reg_addr),
    .reg_wdata      (reg_wdata),
    .reg_rdata      (reg_rdata),
    .reg_rvalid     (reg_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reg_write(input logic [4:0] addr, input logic [31:0] data);
    reg_we    = 1'b1;
    reg_addr  = addr;
    reg_wdata = data;
    tick();
    reg_we    = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic reg_read(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    reg_re   = 1'b1;
    reg_addr = addr;
    tick();
    reg_re   = 1'b0;
    check({tag, "_rvalid"}, 64'(reg_rvalid), 64'd1);
    check(tag, 64'(reg_rdata), 64'(exp));
  endtask

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    rst            = 1'b1;
    ev_icache_miss = 1'b0;
    ev_dcache_miss = 1'b0;
    ev_uncache     = 1'b0;
    ev_retire      = 2'd0;
    ev_branch      = 1'b0;
    ev_mispredict  = 1'b0;
    ev_stop        = 1'b0;
    reg_we         = 1'b0;
    reg_re         = 1'b0;
    reg_addr       = '0;
    reg_wdata      = '0;

    // Reset state
    tick();
    tick();
    check("rst_rvalid", 64'(reg_rvalid), 64'd0);
    check("rst_rdata", 64'(reg_rdata), 64'd0);
    rst = 1'b0;
    tick();
    reg_read(5'd1, 32'h0, "rst_status");
    reg_read(5'd0, 32'h0, "rst_ctrl");

    // 100 cycles retiring 2 instructions each, then snapshot
    reg_write(5'd0, 32'h1);
    ev_retire = 2'd2;
    for (int i = 0; i < 100; i++) tick();
    ev_retire = 2'd0;
    reg_write(5'd0, 32'h5);
    tick();
    reg_read(5'd1, 32'h5, "a_status");
    reg_read(5'd2, 32'd101, "a_cycle_lo");
    // Back-to-back reads of instr low/high, then rvalid must drop
    reg_re   = 1'b1;
    reg_addr = 5'd4;
    tick();
    check("a_b2b0_rvalid", 64'(reg_rvalid), 64'd1);
    check("a_instr_lo", 64'(reg_rdata), 64'd200);
    reg_addr = 5'd5;
    tick();
    check("a_b2b1_rvalid", 64'(reg_rvalid), 64'd1);
    check("a_instr_hi", 64'(reg_rdata), 64'd0);
    reg_re = 1'b0;
    tick();
    check("a_rvalid_drop", 64'(reg_rvalid), 64'd0);

    // Branch / mispredict qualification
    reg_write(5'd0, 32'h3);
    ev_branch     = 1'b1;
    ev_mispredict = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ev_branch = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    ev_mispredict = 1'b0;
    reg_write(5'd0, 32'h5);
    tick();
    reg_read(5'd12, 32'd5, "b_branch");
    reg_read(5'd14, 32'd5, "b_mispred");

    // Clear wins over a coincident I$ miss
    ev_icache_miss = 1'b1;
    tick();
    reg_write(5'd0, 32'h3);
    ev_icache_miss = 1'b0;
    reg_write(5'd0, 32'h5);
    tick();
    reg_read(5'd6, 32'd0, "c_icache_clr");

    // CTRL read alongside an enable write returns the old value
    reg_write(5'd0, 32'h0);
    reg_we    = 1'b1;
    reg_re    = 1'b1;
    reg_addr  = 5'd0;
    reg_wdata = 32'h1;
    tick();
    reg_we = 1'b0;
    reg_re = 1'b0;
    check("c_rw_rvalid", 64'(reg_rvalid), 64'd1);
    check("c_rw_old", 64'(reg_rdata), 64'd0);
    reg_read(5'd0, 32'h1, "c_ctrl_new");

    // Wrap of the I$ counter from all-ones
    reg_write(5'd0, 32'h2);
    force dut.g_cnt[2].u_cnt.count_q = 33'h1_FFFF_FFFF;
    tick();
    release dut.g_cnt[2].u_cnt.count_q;
    reg_write(5'd0, 32'h4);
    tick();
    reg_read(5'd6, 32'hFFFF_FFFF, "d_pre_lo");
    reg_read(5'd7, 32'h1, "d_pre_hi");
    reg_write(5'd0, 32'h1);
    ev_icache_miss = 1'b1;
    reg_write(5'd0, 32'h5);
    reg_write(5'd0, 32'h5);
    ev_icache_miss = 1'b0;
    reg_read(5'd6, 32'd0, "d_wrap0");
    reg_read(5'd6, 32'd1, "d_wrap1");
    reg_read(5'd7, 32'd0, "d_wrap_hi");
    reg_read(5'd1, 32'h25, "d_sticky");
    reg_write(5'd0, 32'h3);
    reg_read(5'd1, 32'h5, "d_sticky_clr");

    // ev_stop with a D$ miss: counted, then HALTED with auto snapshot
    ev_dcache_miss = 1'b1;
    ev_stop        = 1'b1;
    tick();
    ev_stop = 1'b0;
    tick();
    tick();
    ev_dcache_miss = 1'b0;
    reg_read(5'd1, 32'h6, "e_halted");
    reg_read(5'd8, 32'd1, "e_dcache");
    reg_write(5'd0, 32'h4);
    tick();
    reg_read(5'd8, 32'd1, "e_dcache_frozen");
    ev_stop = 1'b1;
    tick();
    ev_stop = 1'b0;
    reg_read(5'd1, 32'h4, "e_stop_idle");

    // Unmapped reads, ignored writes to read-only addresses
    reg_read(5'd20, 32'h0, "f_unmapped20");
    reg_read(5'd31, 32'h0, "f_unmapped31");
    reg_write(5'd1, 32'hFFFF_FFFF);
    reg_write(5'd8, 32'h0);
    reg_read(5'd8, 32'd1, "f_ro_snap");
    reg_read(5'd1, 32'h4, "f_ro_status");

    // Reset mid-RUN with a read in flight
    reg_write(5'd0, 32'h1);
    ev_dcache_miss = 1'b1;
    tick();
    reg_re   = 1'b1;
    reg_addr = 5'd1;
    rst      = 1'b1;
    tick();
    reg_re = 1'b0;
    check("g_rst_rvalid", 64'(reg_rvalid), 64'd0);
    check("g_rst_rdata", 64'(reg_rdata), 64'd0);
    tick();
    rst            = 1'b0;
    ev_dcache_miss = 1'b0;
    for (int a = 0; a < 16; a++) begin
      reg_read(5'(a), 32'h0, $sformatf("g_rd%0d", a));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
